seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_step.sv | 40 ++++
 rtl/seq_divider.sv | 102 ++++++++++
 tb/tb_seq_divider.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Package shared by the sequential divider files.
// Contents:
//   DEFAULT_SIZE  - default operand / quotient / remainder width
//   state_t       - FSM state type, with IDLE / RUN / DONE constants
//   cnt_width()   - iteration counter width for a given operand width
package div_pkg;

  localparam int DEFAULT_SIZE = 32;

  // FSM state type. The state values are plain constants so that
  // older tools can read them.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // The counter must be able to hold values from 0 up to size.
  function automatic int cnt_width(input int size);
    return $clog2(size + 1);
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_SIZE);

endpackage

// File: rtl/div_step.sv
// Performs one combinational restoring-division step.
// Ports:
//   iRemainder - current partial remainder (always less than iDivisor)
//   iQuotient  - quotient shift register; its MSB is the next dividend bit
//   iDivisor   - divisor, nonzero
//   oRemainder - partial remainder after this step
//   oQuotient  - quotient register shifted left, with the new quotient bit
//                in the LSB
module div_step
  import div_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic [SIZE-1:0] iRemainder,
  input  logic [SIZE-1:0] iQuotient,
  input  logic [SIZE-1:0] iDivisor,
  output logic [SIZE-1:0] oRemainder,
  output logic [SIZE-1:0] oQuotient
);

  logic [SIZE:0] shifted;
  logic [SIZE:0] trial;

  // The shifted remainder needs SIZE+1 bits. The stored remainder stays
  // below the divisor, so it always fits in SIZE bits.
  // The trial difference wraps modulo 2^(SIZE+1). Its top bit is set
  // exactly when shifted < divisor, so that bit works as the sign bit.
  always_comb begin
    shifted = {iRemainder, iQuotient[SIZE-1]};
    trial   = shifted - {1'b0, iDivisor};
    if (trial[SIZE]) begin
      oRemainder = shifted[SIZE-1:0];
      oQuotient  = {iQuotient[SIZE-2:0], 1'b0};
    end else begin
      oRemainder = trial[SIZE-1:0];
      oQuotient  = {iQuotient[SIZE-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider. It uses one restoring step per clock.
// Ports:
//   Clock       - rising-edge clock
//   Reset       - synchronous reset, active low
//   iStart      - request a division; this is honoured only in IDLE
//   iDividend   - dividend; captured when the start is accepted
//   iDivisor    - divisor; captured when the start is accepted
//   oBusy       - high in RUN and in DONE
//   oDone       - one-cycle pulse when the results become valid
//   oQuotient   - quotient; holds its value until the next accepted start
//   oRemainder  - remainder; holds its value until the next accepted start
//   oDivByZero  - set together with oDone when the divisor was zero
module seq_divider
  import div_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            iStart,
  input  logic [SIZE-1:0] iDividend,
  input  logic [SIZE-1:0] iDivisor,
  output logic            oBusy,
  output logic            oDone,
  output logic [SIZE-1:0] oQuotient,
  output logic [SIZE-1:0] oRemainder,
  output logic            oDivByZero
);

  localparam int            CW   = cnt_width(SIZE);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  state_t          state;
  logic [CW-1:0]   count;
  logic [SIZE-1:0] divisor;
  logic [SIZE-1:0] quot;
  logic [SIZE-1:0] rem;
  logic [SIZE-1:0] rem_next;
  logic [SIZE-1:0] quot_next;

  div_step #(.SIZE(SIZE)) u_step (
    .iRemainder(rem),
    .iQuotient (quot),
    .iDivisor  (divisor),
    .oRemainder(rem_next),
    .oQuotient (quot_next)
  );

  // The quotient register first holds the dividend. Each step shifts one
  // dividend bit out of the top and one quotient bit in at the bottom.
  // The result outputs are loaded only when the FSM enters DONE, so they
  // keep the last result through the next RUN.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state      <= IDLE;
      count      <= '0;
      divisor    <= '0;
      quot       <= '0;
      rem        <= '0;
      oQuotient  <= '0;
      oRemainder <= '0;
      oDivByZero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            if (iDivisor == '0) begin
              state      <= DONE;
              oQuotient  <= '1;
              oRemainder <= iDividend;
              oDivByZero <= 1'b1;
            end else begin
              state      <= RUN;
              divisor    <= iDivisor;
              quot       <= iDividend;
              rem        <= '0;
              count      <= '0;
              oDivByZero <= 1'b0;
            end
          end
        end
        RUN: begin
          rem  <= rem_next;
          quot <= quot_next;
          if (count == LAST) begin
            state      <= DONE;
            oQuotient  <= quot_next;
            oRemainder <= rem_next;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign oBusy = (state != IDLE);
  assign oDone = (state == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking testbench for seq_divider with SIZE = 32.
// It applies a table of directed vectors, then random operands that are
// checked against an arithmetic model. It ends with sequences covering
// starts during RUN, reset during RUN, and back-to-back operation.
module tb_seq_divider;

  localparam int SIZE = 32;

  logic            Clock = 1'b0;
  logic            Reset = 1'b0;
  logic            iStart = 1'b0;
  logic [SIZE-1:0] iDividend = '0;
  logic [SIZE-1:0] iDivisor = '0;
  logic            oBusy;
  logic            oDone;
  logic [SIZE-1:0] oQuotient;
  logic [SIZE-1:0] oRemainder;
  logic            oDivByZero;

  int testCount = 0;
  int failCount = 0;

  seq_divider #(.SIZE(SIZE)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .iStart    (iStart),
    .iDividend (iDividend),
    .iDivisor  (iDivisor),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oQuotient (oQuotient),
    .oRemainder(oRemainder),
    .oDivByZero(oDivByZero)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [SIZE-1:0] dividend;
    logic [SIZE-1:0] divisor;
    logic [SIZE-1:0] expQ;
    logic [SIZE-1:0] expR;
    logic            expDbz;
    int              expLat;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Reference model written as plain arithmetic on the operands.
  task automatic modelDiv(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                          output vec_t v);
    v.dividend = a;
    v.divisor  = b;
    if (b == '0) begin
      v.expQ   = '1;
      v.expR   = a;
      v.expDbz = 1'b1;
      v.expLat = 1;
    end else begin
      v.expQ   = a / b;
      v.expR   = a % b;
      v.expDbz = 1'b0;
      v.expLat = SIZE + 1;
    end
  endtask

  // Drive a start for one edge, then scramble the operand inputs.
  task automatic applyStimulus(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    iStart    = 1'b1;
    iDividend = a;
    iDivisor  = b;
    @(posedge Clock);
    #1;
    iStart    = 1'b0;
    iDividend = $urandom;
    iDivisor  = $urandom;
  endtask

  // Count the edges from the accepting edge (counted as 1) until oDone
  // is seen. The wait is bounded.
  task automatic waitDone(output int lat);
    lat = 1;
    while (!oDone && lat < 100) begin
      @(posedge Clock);
      #1;
      lat++;
    end
  endtask

  task automatic runVector(input string name, input vec_t v);
    int lat;
    applyStimulus(v.dividend, v.divisor);
    checkOutput({name, " busy"}, 64'(oBusy), 64'd1);
    waitDone(lat);
    checkOutput({name, " latency"}, 64'(lat), 64'(v.expLat));
    checkOutput({name, " quotient"}, 64'(oQuotient), 64'(v.expQ));
    checkOutput({name, " remainder"}, 64'(oRemainder), 64'(v.expR));
    checkOutput({name, " divbyzero"}, 64'(oDivByZero), 64'(v.expDbz));
    @(posedge Clock);
    #1;
    checkOutput({name, " done single"}, 64'(oDone), 64'd0);
    checkOutput({name, " idle busy"}, 64'(oBusy), 64'd0);
    checkOutput({name, " quotient hold"}, 64'(oQuotient), 64'(v.expQ));
  endtask

  initial begin
    vec_t v;
    int   lat;
    int   doneCount;
    int   lastDone;

    vecs[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33};
    vecs[1] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33};
    vecs[2] = '{32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 33};
    vecs[3] = '{32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1};
    vecs[4] = '{32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33};
    vecs[5] = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 33};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 33};
    vecs[7] = '{32'h8000_0000, 32'h7, 32'h1249_2492, 32'd2, 1'b0, 33};

    // Reset with iStart held high; the start must be ignored.
    Reset     = 1'b0;
    iStart    = 1'b1;
    iDividend = 32'd77;
    iDivisor  = 32'd3;
    repeat (3) @(posedge Clock);
    #1;
    checkOutput("reset busy", 64'(oBusy), 64'd0);
    checkOutput("reset done", 64'(oDone), 64'd0);
    checkOutput("reset quotient", 64'(oQuotient), 64'd0);
    checkOutput("reset remainder", 64'(oRemainder), 64'd0);
    checkOutput("reset divbyzero", 64'(oDivByZero), 64'd0);
    Reset  = 1'b1;
    iStart = 1'b0;
    @(posedge Clock);
    #1;
    checkOutput("post reset idle", 64'(oBusy), 64'd0);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      runVector($sformatf("vec%0d", i), vecs[i]);
    end

    // The divide-by-zero case keeps oBusy high for one cycle only.
    applyStimulus(32'd9, 32'd0);
    checkOutput("dbz busy first", 64'(oBusy), 64'd1);
    @(posedge Clock);
    #1;
    checkOutput("dbz busy second", 64'(oBusy), 64'd0);

    // Random operands checked against the model.
    for (int i = 0; i < 24; i++) begin
      logic [SIZE-1:0] a;
      logic [SIZE-1:0] b;
      a = $urandom;
      case (i % 4)
        0:       b = $urandom;
        1:       b = 32'($urandom_range(1, 16));
        2:       b = (i % 8 == 2) ? 32'd0 : 32'($urandom_range(1, 65535));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      modelDiv(a, b, v);
      runVector($sformatf("rand%0d", i), v);
    end

    // A start during RUN is ignored; a later start is honoured.
    iStart = 1'b1; iDividend = 32'd100; iDivisor = 32'd7;
    @(posedge Clock);
    #1;
    iStart = 1'b0;
    repeat (9) @(posedge Clock);
    #1;
    iStart = 1'b1; iDividend = 32'd50; iDivisor = 32'd5;
    @(posedge Clock);
    #1;
    iStart = 1'b0;
    lat = 11;
    while (!oDone && lat < 100) begin
      @(posedge Clock);
      #1;
      lat++;
    end
    checkOutput("ignore start latency", 64'(lat), 64'd33);
    checkOutput("ignore start quotient", 64'(oQuotient), 64'd14);
    checkOutput("ignore start remainder", 64'(oRemainder), 64'd2);
    @(posedge Clock);
    #1;
    modelDiv(32'd50, 32'd5, v);
    runVector("after ignore", v);

    // Reset in the middle of RUN aborts the division without an oDone pulse.
    applyStimulus(32'd1000, 32'd3);
    repeat (19) @(posedge Clock);
    #1;
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    checkOutput("abort busy", 64'(oBusy), 64'd0);
    checkOutput("abort quotient", 64'(oQuotient), 64'd0);
    checkOutput("abort remainder", 64'(oRemainder), 64'd0);
    checkOutput("abort divbyzero", 64'(oDivByZero), 64'd0);
    doneCount = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge Clock);
      #1;
      if (oDone) doneCount++;
    end
    checkOutput("abort no done", 64'(doneCount), 64'd0);
    modelDiv(32'd1000, 32'd3, v);
    runVector("after abort", v);

    // Back-to-back starts: iStart is held high continuously.
    iStart = 1'b1; iDividend = 32'd100; iDivisor = 32'd7;
    doneCount = 0;
    lastDone  = 0;
    for (int c = 1; c <= 110; c++) begin
      @(posedge Clock);
      #1;
      if (oDone) begin
        doneCount++;
        if (doneCount == 1)
          checkOutput("b2b first done", 64'(c), 64'd33);
        else
          checkOutput("b2b period", 64'(c - lastDone), 64'(SIZE + 2));
        checkOutput("b2b quotient", 64'(oQuotient), 64'd14);
        lastDone = c;
      end
    end
    checkOutput("b2b pulse count", 64'(doneCount), 64'd3);
    iStart = 1'b0;
    repeat (40) @(posedge Clock);
    #1;
    checkOutput("b2b final idle", 64'(oBusy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
